// File: rtl/op_seq_pkg.sv
// op_seq_pkg: shared types and helpers for the operand/result sequencer.
//   op_seq_state_e : sequencer FSM states (IDLE, RUN, DONE)
//   addr_wrap()    : (base + offset) modulo depth, used for the wrapping window
package op_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } op_seq_state_e;

  function automatic int unsigned addr_wrap(input int unsigned base,
                                            input int unsigned offset,
                                            input int unsigned depth);
    return (base + offset) % depth;
  endfunction

endpackage

// File: rtl/op_seq_tag_fifo.sv
// op_seq_tag_fifo: small synchronous FIFO holding the addresses of issued,
// not yet retired operations.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push, din    : write din (ignored while full)
//   pop          : drop head entry (ignored while empty)
//   flush        : empty the FIFO; wins over push/pop
//   full, empty  : occupancy flags
//   head         : oldest entry, valid while !empty
// Simultaneous push and pop are both performed and leave occupancy unchanged.
module op_seq_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointer increment that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/op_seq_ctrl.sv
// op_seq_ctrl: walks a wrapping window of operand addresses, issues each to
// the operation unit (valid/ready), tracks in-flight addresses in a tag FIFO
// and turns each returned result into a registered result-memory write.
//   clk_i, rst_i             : clock, asynchronous active-high reset
//   start_i, abort_i         : job control (start sampled in IDLE only)
//   base_addr_i, count_i     : job window, sampled with start_i
//   busy_o, done_o, err_o    : status (done_o one-cycle pulse, err_o sticky)
//   rd_addr_o, op_valid_o    : issue side, op_ready_i accepts
//   res_valid_i, res_data_i  : result return
//   wr_en_o/addr_o/data_o    : result-memory write, one cycle after result
// Optional feature: define OP_SEQ_PERF_EN to add perf_cycles_o[31:0], a
// saturating count of RUN cycles, cleared when a job is accepted.
module op_seq_ctrl
  import op_seq_pkg::*;
#(
  parameter int  MEM_DEPTH       = 8,
  parameter int  MEM_WIDTH       = 32,
  parameter int  MAX_OUTSTANDING = 2,
  localparam int AW              = $clog2(MEM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [AW-1:0]        base_addr_i,
  input  logic [AW:0]          count_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
`ifdef OP_SEQ_PERF_EN
  output logic [31:0]          perf_cycles_o,
`endif
  output logic [AW-1:0]        rd_addr_o,
  output logic                 op_valid_o,
  input  logic                 op_ready_i,
  input  logic                 res_valid_i,
  input  logic [MEM_WIDTH-1:0] res_data_i,
  output logic                 wr_en_o,
  output logic [AW-1:0]        wr_addr_o,
  output logic [MEM_WIDTH-1:0] wr_data_o
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(MEM_DEPTH);

  op_seq_state_e        state_q, state_d;
  logic [AW-1:0]        base_q, base_d;
  logic [AW:0]          count_q, count_d;
  logic [AW:0]          issued_q, issued_d;
  logic [AW:0]          retired_q, retired_d;
  logic                 err_q, err_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [MEM_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                 fifo_full, fifo_empty;
  logic [AW-1:0]        fifo_head;
  logic                 abort_act, start_acc, issue, retire;
  logic [AW:0]          count_clamped;

  assign count_clamped = (count_i > DEPTH_CNT) ? DEPTH_CNT : count_i;
  assign abort_act     = abort_i && (state_q != IDLE);
  assign start_acc     = start_i && (state_q == IDLE);

  assign rd_addr_o  = AW'(addr_wrap(32'(base_q), 32'(issued_q), MEM_DEPTH));
  assign op_valid_o = (state_q == RUN) && (issued_q < count_q) && !fifo_full;
  assign issue      = op_valid_o && op_ready_i;
  // A result that races an abort is dropped along with its tag.
  assign retire     = res_valid_i && !fifo_empty && !abort_act;

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE) && !abort_i;
  assign err_o     = err_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

  op_seq_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (AW)
  ) u_tag_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (issue && !abort_act),
    .din   (rd_addr_o),
    .pop   (retire),
    .flush (abort_act),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    err_d     = err_q || (res_valid_i && fifo_empty);
    wr_en_d   = retire;
    wr_addr_d = retire ? fifo_head : wr_addr_q;
    wr_data_d = retire ? res_data_i : wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          base_d    = base_addr_i;
          count_d   = count_clamped;
          issued_d  = '0;
          retired_d = '0;
          state_d   = (count_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue) issued_d = issued_q + (AW + 1)'(1);
        if (retire) begin
          retired_d = retired_q + (AW + 1)'(1);
          if (retired_q + (AW + 1)'(1) == count_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_act) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      count_q   <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef OP_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_acc)                              perf_d = '0;
    else if (state_q == RUN && perf_q != '1)    perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: doc/op_seq_ctrl.md
# op_seq_ctrl

Sequencer for the operand/result datapath. Walks a contiguous, wrapping window of operand addresses and issues each address to the operation unit with a valid/ready handshake. It tracks in-flight addresses in a small tag FIFO and turns each returned result into a result-memory write. It sits between the testbench/host control (start, base, count) and the operation unit plus the result memory.

## Interface
- MEM_DEPTH, 8, entries in operand/result memories; AW = $clog2(MEM_DEPTH)
- MEM_WIDTH, 32, result data width
- MAX_OUTSTANDING, 2, tag FIFO depth (issued but not yet retired), ≥1
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  start request, sampled in IDLE only
- abort_i  in  1  abandon current job
- base_addr_i  in  AW  first operand address, sampled with start_i
- count_i  in  AW+1  entries to process, sampled with start_i
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse, job completed
- err_o  out  1  sticky: result arrived with empty tag FIFO
- rd_addr_o  out  AW  operand1/operand2 read address
- op_valid_o  out  1  operands at rd_addr_o valid for issue
- op_ready_i  in  1  operation unit accepts issue
- res_valid_i  in  1  operation unit result valid
- res_data_i  in  MEM_WIDTH  result value
- wr_en_o  out  1  result-memory write enable
- wr_addr_o  out  AW  result-memory write address
- wr_data_o  out  MEM_WIDTH  result-memory write data

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start_i=1 latches base and count. If count_i > MEM_DEPTH, it is clamped to MEM_DEPTH. Count 0 goes to DONE; otherwise the FSM goes to RUN with issued = retired = 0.
- RUN:
  - rd_addr_o = (base + issued) mod MEM_DEPTH, so the window wraps past MEM_DEPTH-1 to 0.
  - op_valid_o = (issued < count) && FIFO not full.
  - Issue transfer = op_valid_o && op_ready_i: push rd_addr_o into the FIFO and increment issued.
  - res_valid_i pops the FIFO head and increments retired. The registered write carries the popped address and res_data_i.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - res_valid_i with an empty FIFO sets err_o, produces no write, and leaves retired unchanged.
  - When retired reaches count, the FSM goes to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i in RUN or DONE is ignored.
- abort_i (RUN or DONE, highest priority): next state IDLE, FIFO flushed, no done_o. A pending registered write from the previous cycle still completes.
- busy_o = state != IDLE.
- err_o clears only on reset.

## Timing
- Reset values: state IDLE, busy_o 0, done_o 0, err_o 0, op_valid_o 0, rd_addr_o 0, wr_en_o 0, wr_addr_o 0, wr_data_o 0, FIFO empty.
- start_i at edge N gives busy_o=1 and op_valid_o=1 from N+1.
- op_valid_o and rd_addr_o are combinational from registered state. They do not depend on op_ready_i.
- Write latency: res_valid_i at edge N gives wr_en_o/wr_addr_o/wr_data_o valid during cycle N+1 (one cycle).
- Last retirement at edge N gives done_o high during N+1 and busy_o low from N+2.
- Peak throughput is one issue and one retire per cycle when MAX_OUTSTANDING ≥ the operation unit latency.

## Configuration
- OP_SEQ_PERF_EN defined: adds output perf_cycles_o [31:0].
  - Cleared at start acceptance.
  - Increments every RUN cycle; saturates at all-ones.
  - Holds after DONE or abort.
- OP_SEQ_PERF_EN undefined: no port, no counter logic.

## Structure
- Package op_seq_pkg holds:
  - state enum op_seq_state_e {IDLE, RUN, DONE}.
  - function addr_wrap(base, offset, depth).
- Sub-module op_seq_tag_fifo: synchronous FIFO, parameters DEPTH and WIDTH. Ports push, pop, flush, full, empty, head. Supports simultaneous push/pop and async reset.

## Test plan
- Basic: base=0, count=8, op_ready_i=1, results one cycle after issue → writes to addresses 0..7 in order with matching data, one done_o, err_o=0.
- Wrap: base=6, count=4 → rd_addr_o sequence 6,7,0,1; wr_addr_o sequence 6,7,0,1.
- Backpressure/full: MAX_OUTSTANDING=2, op_ready_i=1, results withheld → op_valid_o drops after two issues; it resumes the cycle after the first res_valid_i.
- Edge counts:
  - count=0 → done_o pulses on the cycle after start, with no op_valid_o.
  - count=12 with MEM_DEPTH=8 → exactly 8 writes.
- Abort/err: abort_i after 3 issues → busy_o low next cycle, FIFO empty, no done_o. A later spurious res_valid_i → err_o=1 and no wr_en_o.
- Reset mid-RUN: rst_i asserted asynchronously → all outputs at reset values immediately. A new start after release runs cleanly.
